// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and loader FSM state encoding.
// The LCD scan block imports the same size constants.
package fb_pkg;

  localparam int IMG_WIDTH  = 200;
  localparam int IMG_HEIGHT = 138;
  localparam int PIXELS     = IMG_WIDTH * IMG_HEIGHT;
  localparam int FB_ADDR_W  = 15;

  localparam logic [7:0] SYNC_B0 = 8'hA5;
  localparam logic [7:0] SYNC_B1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_SYNC0,
    ST_SYNC1,
    ST_HI,
    ST_LO,
    ST_FLUSH,
    ST_DONE
  } fb_state_e;

endpackage

// File: rtl/fb_stream_loader_if.sv
// Byte-stream input plus frame-buffer write port of the stream loader.
interface fb_stream_loader_if #(
  parameter int ADDR_W = fb_pkg::FB_ADDR_W
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              rd_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              frame_done;
  logic              err_timeout;

  modport slave (
    input  s_data, s_valid, rd_busy,
    output s_ready, mem_we, mem_addr, mem_din, frame_done, err_timeout
  );

  modport master (
    output s_data, s_valid, rd_busy,
    input  s_ready, mem_we, mem_addr, mem_din, frame_done, err_timeout
  );
endinterface

// File: rtl/fb_pixel_fifo.sv
// Small show-ahead pixel FIFO between byte assembly and the RAM write port.
// Pop on empty is ignored; push on full is ignored unless a pop frees a slot
// in the same cycle. clear empties the FIFO and wins over push/pop.
module fb_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         PixelClk,
  input  logic         nRST,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointer/occupancy update; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge PixelClk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/fb_stream_loader.sv
// Byte stream to frame-buffer loader: hunts for the A5 5A header, builds
// RGB565 pixels high byte first, and writes them sequentially into the
// frame-buffer RAM whenever the scan side leaves the port free.
module fb_stream_loader
  import fb_pkg::*;
#(
  parameter int IMG_WIDTH  = fb_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = fb_pkg::IMG_HEIGHT,
  parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1_000_000
) (
  input logic                PixelClk,
  input logic                nRST,
  fb_stream_loader_if.slave  bus
);
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  fb_state_e         state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic        rdy, accept, in_pixel, abort;
  logic        push, pop, fifo_clear, fifo_full, fifo_empty;
  logic [15:0] fifo_dout;

  // Byte acceptance: LO only takes a byte when the assembled pixel has room.
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_SYNC0, ST_SYNC1, ST_HI: rdy = 1'b1;
      ST_LO:                     rdy = !fifo_full;
      default:                   rdy = 1'b0;
    endcase
  end

  assign bus.s_ready = nRST & rdy;
  assign accept      = bus.s_valid & bus.s_ready;
  assign in_pixel    = (state_q == ST_HI) || (state_q == ST_LO);
  assign abort       = in_pixel && !accept && (tmo_q == TMO_LAST);
  // rd_busy is only looked at here: the scan side flags its RAM use a cycle early.
  assign pop         = !fifo_empty && !bus.rd_busy && !abort;

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .clear    (fifo_clear),
    .push     (push),
    .din      ({hi_q, bus.s_data}),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Next-state: header hunt, pixel assembly, flush/done and mid-frame timeout.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    pix_d        = pix_q;
    wr_addr_d    = pop ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    tmo_d        = '0;
    push         = 1'b0;
    fifo_clear   = 1'b0;
    mem_we_d     = pop;
    mem_addr_d   = pop ? wr_addr_q : mem_addr_q;
    mem_din_d    = pop ? fifo_dout : mem_din_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_SYNC0: if (accept && bus.s_data == SYNC_B0) state_d = ST_SYNC1;
      ST_SYNC1: begin
        if (accept) begin
          if (bus.s_data == SYNC_B1) begin
            state_d   = ST_HI;
            pix_d     = '0;
            wr_addr_d = '0;
          end else if (bus.s_data != SYNC_B0) begin
            state_d = ST_SYNC0;
          end
        end
      end
      ST_HI, ST_LO: begin
        if (accept) begin
          if (state_q == ST_HI) begin
            hi_d    = bus.s_data;
            state_d = ST_LO;
          end else begin
            push    = 1'b1;
            pix_d   = pix_q + ADDR_W'(1);
            state_d = (pix_q == LAST_PIX) ? ST_FLUSH : ST_HI;
          end
        end else if (abort) begin
          // Stalled stream: drop queued pixels, keep what already hit the RAM.
          err_d      = 1'b1;
          fifo_clear = 1'b1;
          state_d    = ST_SYNC0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      // Empty FIFO means the last pop has issued; its write lands this cycle.
      ST_FLUSH: if (fifo_empty) begin
        frame_done_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: state_d = ST_SYNC0;
      default: state_d = ST_SYNC0;
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_SYNC0;
      hi_q         <= '0;
      pix_q        <= '0;
      wr_addr_q    <= '0;
      tmo_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      pix_q        <= pix_d;
      wr_addr_q    <= wr_addr_d;
      tmo_q        <= tmo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_fb_stream_loader.sv
// Directed bench: a 2x2 loader (TIMEOUT=16) for protocol corners and a
// default-size loader for backpressure and one full frame.
module tb_fb_stream_loader;
  localparam int NPIX_B = 200 * 138;

  logic PixelClk = 1'b0;
  logic nRST     = 1'b0;
  int   checks = 0, errs = 0;
  int   cyc = 0, last_acc = 0;
  int   qa_a[$], qe_a[$], qa_b[$], qe_b[$];
  logic [15:0] qd_a[$], qd_b[$];
  int   done_a = 0, done_e_a = 0, err_a = 0, err_e_a = 0, done_b = 0;
  bit   rnd_en = 1'b0, rnd_bit = 1'b0, busy_b = 1'b0;

  fb_stream_loader_if #(.ADDR_W(15)) ifa ();
  fb_stream_loader_if #(.ADDR_W(15)) ifb ();

  fb_stream_loader #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .ADDR_W(15),
                     .FIFO_DEPTH(4), .TIMEOUT(16))
    dut_a (.PixelClk(PixelClk), .nRST(nRST), .bus(ifa));

  fb_stream_loader dut_b (.PixelClk(PixelClk), .nRST(nRST), .bus(ifb));

  always #5 PixelClk = ~PixelClk;

  assign ifb.rd_busy = rnd_en ? rnd_bit : busy_b;
  always @(negedge PixelClk) rnd_bit = 1'($urandom_range(0, 1));

  // cyc numbers the rising edge whose results are being sampled
  always @(posedge PixelClk) begin
    #1;
    cyc++;
    if (ifa.mem_we) begin qa_a.push_back(int'(ifa.mem_addr)); qd_a.push_back(ifa.mem_din); qe_a.push_back(cyc); end
    if (ifa.frame_done)  begin done_a++; done_e_a = cyc; end
    if (ifa.err_timeout) begin err_a++;  err_e_a  = cyc; end
    if (ifb.mem_we) begin qa_b.push_back(int'(ifb.mem_addr)); qd_b.push_back(ifb.mem_din); qe_b.push_back(cyc); end
    if (ifb.frame_done) done_b++;
  end

  function automatic logic [15:0] pixf(input int i);
    return 16'(i * 40503) ^ 16'hBEEF;
  endfunction

  task automatic send(input bit sel, input logic [7:0] b);
    int n = 0;
    @(negedge PixelClk);
    if (sel) begin ifb.s_data = b; ifb.s_valid = 1'b1; end
    else     begin ifa.s_data = b; ifa.s_valid = 1'b1; end
    while (!(sel ? ifb.s_ready : ifa.s_ready) && n < 200) begin @(negedge PixelClk); n++; end
    if (n >= 200) begin checks++; errs++; $display("FAIL send_timeout: byte %h not accepted, waited %0d cycles, required < 200", b, n); end
    @(posedge PixelClk);
    last_acc = cyc + 1;
    #2;
    if (sel) ifb.s_valid = 1'b0; else ifa.s_valid = 1'b0;
  endtask

  task automatic clear_a();
    qa_a.delete(); qd_a.delete(); qe_a.delete();
    done_a = 0; done_e_a = 0; err_a = 0; err_e_a = 0;
  endtask

  task automatic send_frame_a(input logic [15:0] p0, p1, p2, p3);
    logic [15:0] p [4];
    p = '{p0, p1, p2, p3};
    send(0, 8'hA5); send(0, 8'h5A);
    for (int i = 0; i < 4; i++) begin send(0, p[i][15:8]); send(0, p[i][7:0]); end
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (done_a == 0 && n < 50) begin @(negedge PixelClk); n++; end
    repeat (5) @(negedge PixelClk);
  endtask

  task automatic test_reset();
    ifa.s_data = 8'h00; ifa.s_valid = 1'b0; ifa.rd_busy = 1'b0;
    ifb.s_data = 8'h00; ifb.s_valid = 1'b0;
    repeat (3) @(negedge PixelClk);
    checks++; if (ifa.mem_we !== 1'b0)       begin errs++; $display("FAIL reset_mem_we: got %b want 0", ifa.mem_we); end
    checks++; if (ifa.mem_addr !== 15'd0)    begin errs++; $display("FAIL reset_mem_addr: got %h want 0", ifa.mem_addr); end
    checks++; if (ifa.mem_din !== 16'd0)     begin errs++; $display("FAIL reset_mem_din: got %h want 0", ifa.mem_din); end
    checks++; if (ifa.frame_done !== 1'b0)   begin errs++; $display("FAIL reset_frame_done: got %b want 0", ifa.frame_done); end
    checks++; if (ifa.err_timeout !== 1'b0)  begin errs++; $display("FAIL reset_err: got %b want 0", ifa.err_timeout); end
    checks++; if (ifa.s_ready !== 1'b0)      begin errs++; $display("FAIL reset_s_ready: got %b want 0", ifa.s_ready); end
    nRST = 1'b1;
    @(negedge PixelClk);
    checks++; if (ifa.s_ready !== 1'b1)      begin errs++; $display("FAIL sync0_s_ready: got %b want 1", ifa.s_ready); end
  endtask

  task automatic test_frame();
    logic [15:0] exp [4];
    exp = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    clear_a();
    send_frame_a(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    wait_done_a();
    checks++; if (qa_a.size() != 4) begin errs++; $display("FAIL frame_nwrites: got %0d want 4", qa_a.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= qa_a.size() || qa_a[i] != i || qd_a[i] !== exp[i]) begin
        errs++; $display("FAIL frame_write%0d: got addr %0d data %h want addr %0d data %h", i,
                         (i < qa_a.size()) ? qa_a[i] : -1, (i < qd_a.size()) ? qd_a[i] : 16'hxxxx, i, exp[i]);
      end
    end
    checks++; if (done_a != 1) begin errs++; $display("FAIL frame_done_count: got %0d want 1", done_a); end
    checks++;
    if (qe_a.size() == 0 || done_e_a != qe_a[$] + 1) begin
      errs++; $display("FAIL frame_done_timing: done at edge %0d, last write edge %0d, want write+1", done_e_a, (qe_a.size() > 0) ? qe_a[$] : -1);
    end
  endtask

  task automatic test_header();
    logic [7:0] junk [6];
    logic [7:0] pre  [4];
    pre  = '{8'h00, 8'hA5, 8'hA5, 8'h5A};
    junk = '{8'h00, 8'hA5, 8'h00, 8'h5A, 8'h11, 8'h22};
    clear_a();
    foreach (pre[i]) send(0, pre[i]);
    send(0, 8'h11); send(0, 8'h11); send(0, 8'h22); send(0, 8'h22);
    send(0, 8'h33); send(0, 8'h33); send(0, 8'h44); send(0, 8'h44);
    wait_done_a();
    checks++;
    if (qa_a.size() != 4 || qd_a[0] !== 16'h1111 || qd_a[3] !== 16'h4444 || qa_a[3] != 3) begin
      errs++; $display("FAIL header_repeat_a5: got %0d writes, want 4 (1111..4444 at 0..3)", qa_a.size());
    end
    checks++; if (done_a != 1) begin errs++; $display("FAIL header_repeat_done: got %0d want 1", done_a); end
    clear_a();
    foreach (junk[i]) send(0, junk[i]);
    repeat (10) @(negedge PixelClk);
    checks++; if (qa_a.size() != 0) begin errs++; $display("FAIL header_junk_writes: got %0d want 0", qa_a.size()); end
    checks++; if (done_a != 0)      begin errs++; $display("FAIL header_junk_done: got %0d want 0", done_a); end
    send_frame_a(16'hC001, 16'hC002, 16'hC003, 16'hC004);
    wait_done_a();
    checks++;
    if (qa_a.size() != 4 || qa_a[0] != 0 || qd_a[0] !== 16'hC001 || qd_a[3] !== 16'hC004) begin
      errs++; $display("FAIL header_after_junk: got %0d writes, want 4 starting C001 at addr 0", qa_a.size());
    end
  endtask

  task automatic test_timeout();
    int t0, n;
    clear_a();
    send(0, 8'hA5); send(0, 8'h5A); send(0, 8'h12); send(0, 8'h34); send(0, 8'h56);
    t0 = last_acc;
    n = 0;
    while (err_a == 0 && n < 60) begin @(negedge PixelClk); n++; end
    repeat (40) @(negedge PixelClk);
    checks++; if (err_a != 1) begin errs++; $display("FAIL timeout_pulses: got %0d want 1", err_a); end
    checks++; if (err_e_a - t0 != 16) begin errs++; $display("FAIL timeout_latency: got %0d cycles want 16", err_e_a - t0); end
    checks++;
    if (qa_a.size() != 1 || qa_a[0] != 0 || qd_a[0] !== 16'h1234) begin
      errs++; $display("FAIL timeout_writes: got %0d writes, want 1 (1234 at addr 0)", qa_a.size());
    end
    checks++; if (ifa.s_ready !== 1'b1) begin errs++; $display("FAIL timeout_s_ready: got %b want 1", ifa.s_ready); end
    clear_a();
    send_frame_a(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    wait_done_a();
    checks++;
    if (qa_a.size() != 4 || qa_a[0] != 0 || qd_a[0] !== 16'h0F0F || qa_a[3] != 3 || qd_a[3] !== 16'hFF00) begin
      errs++; $display("FAIL timeout_restart: got %0d writes, want 4 from addr 0", qa_a.size());
    end
    checks++; if (err_a != 0) begin errs++; $display("FAIL timeout_spurious: got %0d pulses want 0", err_a); end
  endtask

  task automatic test_reset_mid();
    clear_a();
    send(0, 8'hA5); send(0, 8'h5A);
    send(0, 8'h11); send(0, 8'h11); send(0, 8'h22); send(0, 8'h22);
    repeat (3) @(negedge PixelClk);
    checks++;
    if (ifa.mem_addr !== 15'd1 || ifa.mem_din !== 16'h2222) begin
      errs++; $display("FAIL midframe_pre: got addr %h data %h want 1 / 2222", ifa.mem_addr, ifa.mem_din);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (ifa.mem_we !== 1'b0 || ifa.mem_addr !== 15'd0 || ifa.mem_din !== 16'd0 ||
        ifa.frame_done !== 1'b0 || ifa.err_timeout !== 1'b0 || ifa.s_ready !== 1'b0) begin
      errs++; $display("FAIL midframe_reset: got we %b addr %h din %h done %b err %b rdy %b want all 0",
                       ifa.mem_we, ifa.mem_addr, ifa.mem_din, ifa.frame_done, ifa.err_timeout, ifa.s_ready);
    end
    repeat (2) @(negedge PixelClk);
    nRST = 1'b1;
    clear_a();
    send_frame_a(16'hAA01, 16'hAA02, 16'hAA03, 16'hAA04);
    wait_done_a();
    checks++;
    if (qa_a.size() != 4 || qa_a[0] != 0 || qd_a[0] !== 16'hAA01 || qa_a[3] != 3 || qd_a[3] !== 16'hAA04) begin
      errs++; $display("FAIL midframe_recover: got %0d writes, want 4 AA01..AA04 at 0..3", qa_a.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    bit stalled;
    int n;
    busy_b = 1'b1;
    send(1, 8'hA5); send(1, 8'h5A);
    for (int i = 0; i < 4; i++) begin p = pixf(i); send(1, p[15:8]); send(1, p[7:0]); end
    p = pixf(4);
    send(1, p[15:8]);
    @(negedge PixelClk);
    ifb.s_data = p[7:0]; ifb.s_valid = 1'b1;
    stalled = 1'b1;
    repeat (4) begin if (ifb.s_ready !== 1'b0) stalled = 1'b0; @(negedge PixelClk); end
    checks++; if (!stalled)          begin errs++; $display("FAIL bp_s_ready: got s_ready high while FIFO full, want 0"); end
    checks++; if (qa_b.size() != 0)  begin errs++; $display("FAIL bp_no_write: got %0d writes want 0", qa_b.size()); end
    busy_b = 1'b0;
    n = 0;
    while (!ifb.s_ready && n < 20) begin @(negedge PixelClk); n++; end
    @(posedge PixelClk);
    #2 ifb.s_valid = 1'b0;
    repeat (6) @(negedge PixelClk);
    checks++; if (qa_b.size() != 5) begin errs++; $display("FAIL bp_nwrites: got %0d want 5", qa_b.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= qa_b.size() || qa_b[i] != i || qd_b[i] !== pixf(i)) begin
        errs++; $display("FAIL bp_write%0d: got addr %0d data %h want addr %0d data %h", i,
                         (i < qa_b.size()) ? qa_b[i] : -1, (i < qd_b.size()) ? qd_b[i] : 16'hxxxx, i, pixf(i));
      end
    end
    checks++;
    if (qe_b.size() < 4 || qe_b[3] - qe_b[0] != 3) begin
      errs++; $display("FAIL bp_consecutive: got span %0d want 3", (qe_b.size() >= 4) ? qe_b[3] - qe_b[0] : -1);
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] p;
    int n, bad;
    rnd_en = 1'b1;
    for (int i = 5; i < NPIX_B; i++) begin
      p = pixf(i);
      send(1, p[15:8]); send(1, p[7:0]);
      if (errs > 20) break;
    end
    n = 0;
    while (done_b == 0 && n < 300) begin @(negedge PixelClk); n++; end
    rnd_en = 1'b0;
    repeat (5) @(negedge PixelClk);
    bad = 0;
    foreach (qa_b[i]) if (qa_b[i] != i || qd_b[i] !== pixf(i)) bad++;
    checks++; if (qa_b.size() != NPIX_B) begin errs++; $display("FAIL full_nwrites: got %0d want %0d", qa_b.size(), NPIX_B); end
    checks++; if (bad != 0) begin errs++; $display("FAIL full_data: got %0d bad writes want 0", bad); end
    checks++;
    if (qa_b.size() == 0 || qa_b[$] != NPIX_B - 1) begin
      errs++; $display("FAIL full_last_addr: got %0d want %0d", (qa_b.size() > 0) ? qa_b[$] : -1, NPIX_B - 1);
    end
    checks++; if (done_b != 1) begin errs++; $display("FAIL full_done: got %0d want 1", done_b); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_header();
    test_timeout();
    test_reset_mid();
    test_backpressure();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
